// File: rtl/fpnew_classify_arbiter.sv
// Round-robin shared FCLASS unit: NumReq valid/ready requesters feed one classifier.
// Define FPNEW_CLASSIFY_PIPE_EN to add a registered input stage (latency 2 instead of 1).
module fpnew_classify_arbiter #(
  parameter int unsigned FpFormat = 0,
  parameter int unsigned NumReq   = 4,
  parameter int unsigned TagWidth = 4,
  localparam int unsigned ExpBits = (FpFormat == 1) ? 11 :
                                    ((FpFormat == 2) || (FpFormat == 3)) ? 5 : 8,
  localparam int unsigned ManBits = (FpFormat == 0) ? 23 : (FpFormat == 1) ? 52 :
                                    (FpFormat == 2) ? 10 : (FpFormat == 3) ? 2 : 7,
  localparam int unsigned WIDTH   = 1 + ExpBits + ManBits,
  localparam int unsigned IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumReq-1:0]                  req_valid_i,
  output logic [NumReq-1:0]                  req_ready_o,
  input  logic [NumReq-1:0][WIDTH-1:0]       req_operand_i,
  input  logic [NumReq-1:0]                  req_is_boxed_i,
  input  logic [NumReq-1:0][TagWidth-1:0]    req_tag_i,
  input  logic                               flush_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [9:0]                         out_class_o,
  output logic [IdWidth-1:0]                 out_reqid_o,
  output logic [TagWidth-1:0]                out_tag_o,
  output logic                               busy_o
);

  function automatic logic [9:0] classify(input logic [WIDTH-1:0] op, input logic boxed);
    logic               sign;
    logic [ExpBits-1:0] expo;
    logic [ManBits-1:0] man;
    logic [9:0]         cls;
    sign = op[WIDTH-1];
    expo = op[WIDTH-2 -: ExpBits];
    man  = op[ManBits-1:0];
    cls  = '0;
    if (!boxed) begin
      cls[9] = 1'b1;
    end else if (&expo) begin
      if (man == '0) begin
        if (sign) cls[0] = 1'b1;
        else      cls[7] = 1'b1;
      end else if (man[ManBits-1]) begin
        cls[9] = 1'b1;
      end else begin
        cls[8] = 1'b1;
      end
    end else if (expo == '0) begin
      if (man == '0) begin
        if (sign) cls[3] = 1'b1;
        else      cls[4] = 1'b1;
      end else begin
        if (sign) cls[2] = 1'b1;
        else      cls[5] = 1'b1;
      end
    end else begin
      if (sign) cls[1] = 1'b1;
      else      cls[6] = 1'b1;
    end
    return cls;
  endfunction

  logic [IdWidth-1:0]  rr_ptr;
  logic                grant_found;
  logic [IdWidth-1:0]  grant_idx;
  logic [IdWidth-1:0]  scan_idx;
  logic                accept;
  logic                load_p1;
  logic [9:0]          class_in;
  logic [IdWidth-1:0]  reqid_in;
  logic [TagWidth-1:0] tag_in;
  logic                vld_p1;
  logic [9:0]          class_p1;
  logic [IdWidth-1:0]  reqid_p1;
  logic [TagWidth-1:0] tag_p1;

  // First valid requester at or after rr_ptr, wrapping modulo NumReq
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      scan_idx = IdWidth'((32'(rr_ptr) + k) % NumReq);
      if (!grant_found && req_valid_i[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant_idx] = 1'b1;
  end

`ifdef FPNEW_CLASSIFY_PIPE_EN
  // Stage p0: granted request registered ahead of the classifier
  logic                vld_p0;
  logic [WIDTH-1:0]    operand_p0;
  logic                boxed_p0;
  logic [IdWidth-1:0]  reqid_p0;
  logic [TagWidth-1:0] tag_p0;
  logic                ready_p0;

  assign ready_p0 = !vld_p1 || out_ready_i;
  assign accept   = grant_found && !flush_i && !rst_i && (!vld_p0 || ready_p0);
  assign load_p1  = vld_p0 && ready_p0 && !flush_i;
  assign class_in = classify(operand_p0, boxed_p0);
  assign reqid_in = reqid_p0;
  assign tag_in   = tag_p0;
  assign busy_o   = vld_p0 || vld_p1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        vld_p0 <= 1'b0;
    else if (flush_i) vld_p0 <= 1'b0;
    else if (accept)  vld_p0 <= 1'b1;
    else if (ready_p0) vld_p0 <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      operand_p0 <= req_operand_i[grant_idx];
      boxed_p0   <= req_is_boxed_i[grant_idx];
      reqid_p0   <= grant_idx;
      tag_p0     <= req_tag_i[grant_idx];
    end
  end
`else
  assign accept   = grant_found && !flush_i && !rst_i && (!vld_p1 || out_ready_i);
  assign load_p1  = accept;
  assign class_in = classify(req_operand_i[grant_idx], req_is_boxed_i[grant_idx]);
  assign reqid_in = grant_idx;
  assign tag_in   = req_tag_i[grant_idx];
  assign busy_o   = vld_p1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       rr_ptr <= '0;
    else if (accept) rr_ptr <= IdWidth'((32'(grant_idx) + 1) % NumReq);
  end

  // Stage p1: classification result held until consumed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      class_p1 <= '0;
      reqid_p1 <= '0;
      tag_p1   <= '0;
    end else begin
      if (flush_i)          vld_p1 <= 1'b0;
      else if (load_p1)     vld_p1 <= 1'b1;
      else if (out_ready_i) vld_p1 <= 1'b0;
      if (load_p1) begin
        class_p1 <= class_in;
        reqid_p1 <= reqid_in;
        tag_p1   <= tag_in;
      end
    end
  end

  assign out_valid_o = vld_p1;
  assign out_class_o = class_p1;
  assign out_reqid_o = reqid_p1;
  assign out_tag_o   = tag_p1;

endmodule

// File: tb/tb_fpnew_classify_arbiter.sv
// Scoreboard bench for fpnew_classify_arbiter (FP32, 4 requesters, default latency-1 build).
module tb_fpnew_classify_arbiter;
  localparam int N  = 4;
  localparam int TW = 4;
  localparam int W  = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req_valid, req_ready, req_is_boxed;
  logic [N-1:0][W-1:0]   req_operand;
  logic [N-1:0][TW-1:0]  req_tag;
  logic                  flush, out_valid, out_ready, busy;
  logic [9:0]            out_class;
  logic [1:0]            out_reqid;
  logic [TW-1:0]         out_tag;

  typedef struct packed {
    logic [9:0]    cls;
    logic [1:0]    id;
    logic [TW-1:0] tag;
  } res_t;

  res_t          exp_q[$];
  int            checks = 0;
  int            fails  = 0;
  int            rr_ptr = 0;
  int            g;
  logic [N-1:0]  exp_ready;
  res_t          r;

  fpnew_classify_arbiter #(.FpFormat(0), .NumReq(N), .TagWidth(TW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_operand_i(req_operand), .req_is_boxed_i(req_is_boxed), .req_tag_i(req_tag),
    .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_class_o(out_class), .out_reqid_o(out_reqid), .out_tag_o(out_tag),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // FP32 class from magnitude ranges: zero, subnormal, normal, inf, sNaN, qNaN
  function automatic logic [9:0] ref_class(input logic [31:0] op, input logic boxed);
    logic [31:0] mag;
    logic        neg;
    int          k;
    logic [9:0]  m;
    mag = {1'b0, op[30:0]};
    neg = op[31];
    if (!boxed)                   k = 9;
    else if (mag == 0)            k = neg ? 3 : 4;
    else if (mag < 32'h0080_0000) k = neg ? 2 : 5;
    else if (mag < 32'h7F80_0000) k = neg ? 1 : 6;
    else if (mag == 32'h7F80_0000) k = neg ? 0 : 7;
    else if (mag >= 32'h7FC0_0000) k = 9;
    else                          k = 8;
    m = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom % 5)
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      default: ;
    endcase
    if (($urandom % 4) == 0) v[22:0] = '0;
    return v;
  endfunction

  // Output monitor: compares presented results against the queue head
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", out_valid, exp_q.size() != 0);
      check("busy", busy, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("out_class", out_class, exp_q[0].cls);
        check("out_reqid", out_reqid, exp_q[0].id);
        check("out_tag", out_tag, exp_q[0].tag);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Request monitor: reference round-robin grant and scoreboard push
  always @(negedge clk) begin
    #1;
    if (rst) begin
      exp_q.delete();
      rr_ptr = 0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(rr_ptr + k) % N]) g = (rr_ptr + k) % N;
      exp_ready = '0;
      if (g >= 0 && !flush && exp_q.size() == 0) exp_ready[g] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      if (flush) begin
        exp_q.delete();
      end else if (exp_ready != 0) begin
        r.cls = ref_class(req_operand[g], req_is_boxed[g]);
        r.id  = 2'(g);
        r.tag = req_tag[g];
        exp_q.push_back(r);
        rr_ptr = (g + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid    = '0;
    req_is_boxed = '1;
    req_operand  = '0;
    req_tag      = '0;
    flush        = 1'b0;
    out_ready    = 1'b1;
  endtask

  task automatic check_all_zero(input string tagname);
    check({tagname, "_valid"}, out_valid, 0);
    check({tagname, "_class"}, out_class, 0);
    check({tagname, "_reqid"}, out_reqid, 0);
    check({tagname, "_tag"}, out_tag, 0);
    check({tagname, "_busy"}, busy, 0);
    check({tagname, "_ready"}, req_ready, 0);
  endtask

  logic [31:0] vec_op[8];
  logic        vec_boxed[8];

  initial begin
    rst = 1'b1;
    idle();
    req_valid = '1;
    repeat (2) tick();
    check_all_zero("reset");
    req_valid = '0;
    rst = 1'b0;
    tick();

    // Round robin from a fresh pointer: grants 0,1,2,3,0
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_operand[i] = rand_op();
      req_tag[i]     = 4'(i + 8);
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_grant", req_ready, 4'b0001 << (i % 4));
      @(posedge clk);
      #1;
    end
    idle();
    repeat (2) tick();

    // Single requester class vectors
    vec_op[0] = 32'hFF80_0000; vec_boxed[0] = 1'b1;
    vec_op[1] = 32'h0000_0001; vec_boxed[1] = 1'b1;
    vec_op[2] = 32'h8000_0000; vec_boxed[2] = 1'b1;
    vec_op[3] = 32'h7F80_0001; vec_boxed[3] = 1'b1;
    vec_op[4] = 32'h7FC0_0000; vec_boxed[4] = 1'b1;
    vec_op[5] = 32'h3F80_0000; vec_boxed[5] = 1'b0;
    vec_op[6] = 32'h3F80_0000; vec_boxed[6] = 1'b1;
    vec_op[7] = 32'hBF80_0000; vec_boxed[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_valid       = 4'b0010;
      req_operand[1]  = vec_op[i];
      req_is_boxed[1] = vec_boxed[i];
      req_tag[1]      = 4'(i);
      tick();
    end
    idle();
    repeat (2) tick();

    // Output stall for 3 cycles with all requesters waiting
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_operand[i] = rand_op();
      req_tag[i]     = 4'($urandom);
    end
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", req_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("unstall_accept", req_ready != 0, 1);
    tick();
    idle();
    repeat (2) tick();

    // Flush with a result pending and requester 2 waiting
    req_valid = 4'b0100;
    req_operand[2] = 32'h4000_0000;
    req_tag[2] = 4'hA;
    tick();
    out_ready = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_ready", req_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_cleared", out_valid, 0);
    check("post_flush_ready", req_ready, 4'b0100);
    tick();
    check("post_flush_reqid", out_reqid, 2);
    out_ready = 1'b1;
    req_valid = '0;
    repeat (2) tick();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        req_operand[i]  = rand_op();
        req_is_boxed[i] = ($urandom % 8) != 0;
        req_tag[i]      = 4'($urandom);
      end
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 32) == 0;
      tick();
    end
    idle();
    repeat (3) tick();

    // Reset in the middle of traffic
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_operand[i] = rand_op();
      req_tag[i]     = 4'(i);
    end
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick();
    rst = 1'b0;
    #1;
    check("rst_first_grant", req_ready, 4'b0001);
    tick();
    check("rst_first_reqid", out_reqid, 0);
    idle();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
